// File: rtl/reg_router.sv
// Register-access router: decodes a channel from the slave's register address,
// issues one-cycle write strobes and runs a per-channel read request/ack handshake.
// Define REG_ROUTER_TIMEOUT_EN to bound the read wait by TIMEOUT cycles.
module reg_router #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int BASE_ADDR = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        reg_addr,
  input  logic                     addr_dv,
  input  logic                     rxdv,
  input  logic                     rw_out,
  input  logic [DATA_W-1:0]        rx_d,
  output logic [DATA_W-1:0]        tx_d,
  output logic                     tx_en,
  output logic [NUM_CH-1:0]        wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic [NUM_CH-1:0]        rd_req,
  input  logic [NUM_CH-1:0]        rd_ack,
  input  logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   tx_d_q, tx_d_d;
  logic                tx_en_q, tx_en_d;
  logic [NUM_CH-1:0]   wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_CH-1:0]   rd_req_q, rd_req_d;
  logic                err_q, err_d;

`ifdef REG_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Address decode: an address below BASE_ADDR wraps to a large offset and misses.
  logic [ADDR_W-1:0] offset;
  logic              hit;
  logic [CH_W-1:0]   dec_ch;

  always_comb begin
    offset = reg_addr - BASE_A;
    hit    = addr_dv && (reg_addr >= BASE_A) && (32'(offset) < NUM_CH);
    dec_ch = offset[CH_W-1:0];
  end

  logic              sel_ack;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_ack  = rd_ack[k];
        sel_data = rd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Read handshake: rd_req[ch] is held high until the channel answers with
  // rd_ack[ch] (sampled only while waiting), the access is aborted, or it times out.
  logic set_err;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    ch_d      = ch_q;
    tx_d_d    = tx_d_q;
    tx_en_d   = tx_en_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    rd_req_d  = rd_req_q;
    err_d     = err_q;
    set_err   = 1'b0;
`ifdef REG_ROUTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    if (addr_dv && rxdv && !rw_out && (state_q != RD_WAIT)) begin
      if (hit) begin
        wr_en_d[dec_ch] = 1'b1;
        wr_data_d       = rx_d;
      end else begin
        set_err = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (addr_dv && rw_out && armed_q) begin
          armed_d = 1'b0;
          if (hit) begin
            state_d          = RD_WAIT;
            ch_d             = dec_ch;
            rd_req_d         = '0;
            rd_req_d[dec_ch] = 1'b1;
`ifdef REG_ROUTER_TIMEOUT_EN
            cnt_d            = '0;
`endif
          end else begin
            state_d = RD_DONE;
            tx_d_d  = '1;
            tx_en_d = 1'b1;
            set_err = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (!addr_dv) begin
          rd_req_d = '0;
          state_d  = IDLE;
        end else if (sel_ack) begin
          tx_d_d   = sel_data;
          tx_en_d  = 1'b1;
          rd_req_d = '0;
          state_d  = RD_DONE;
`ifdef REG_ROUTER_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tx_d_d   = '1;
          tx_en_d  = 1'b1;
          rd_req_d = '0;
          set_err  = 1'b1;
          state_d  = RD_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RD_DONE: begin
        if (!addr_dv || !rw_out) begin
          tx_d_d  = '0;
          tx_en_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // One read per addr_dv assertion: re-arm only while the address is idle.
    if (!addr_dv) armed_d = 1'b1;

    if (err_clr) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      ch_q      <= '0;
      tx_d_q    <= '0;
      tx_en_q   <= 1'b0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      rd_req_q  <= '0;
      err_q     <= 1'b0;
`ifdef REG_ROUTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      ch_q      <= ch_d;
      tx_d_q    <= tx_d_d;
      tx_en_q   <= tx_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      err_q     <= err_d;
`ifdef REG_ROUTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign tx_d    = tx_d_q;
  assign tx_en   = tx_en_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign rd_req  = rd_req_q;
  assign err     = err_q;

endmodule

// File: tb/tb_reg_router.sv
// Bench for reg_router: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_router;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 7;
  localparam int BASE_ADDR = 4;
  localparam int TIMEOUT   = 15;

  logic                     clk;
  logic                     reset_n;
  logic [ADDR_W-1:0]        reg_addr;
  logic                     addr_dv;
  logic                     rxdv;
  logic                     rw_out;
  logic [DATA_W-1:0]        rx_d;
  logic [DATA_W-1:0]        tx_d;
  logic                     tx_en;
  logic [NUM_CH-1:0]        wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_CH-1:0]        rd_req;
  logic [NUM_CH-1:0]        rd_ack;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     err;
  logic                     err_clr;

  reg_router #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .reg_addr(reg_addr), .addr_dv(addr_dv),
    .rxdv(rxdv), .rw_out(rw_out), .rx_d(rx_d), .tx_d(tx_d), .tx_en(tx_en),
    .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .err(err), .err_clr(err_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: tracks the outstanding request channel (-1 = none) and
  // whether a response is being presented, then derives outputs from those.
  logic [DATA_W-1:0] m_tx_d    = '0;
  logic              m_tx_en   = 1'b0;
  logic [NUM_CH-1:0] m_wr_en   = '0;
  logic [DATA_W-1:0] m_wr_data = '0;
  logic [NUM_CH-1:0] m_rd_req  = '0;
  logic              m_err     = 1'b0;
  int                m_pend    = -1;
  bit                m_hold    = 1'b0;
  bit                m_armed   = 1'b1;
  int                m_cnt     = 0;

  task automatic model_reset();
    m_tx_d = '0; m_tx_en = 1'b0; m_wr_en = '0; m_wr_data = '0;
    m_rd_req = '0; m_err = 1'b0; m_pend = -1; m_hold = 1'b0;
    m_armed = 1'b1; m_cnt = 0;
  endtask

  task automatic model_step();
    int off;
    bit hit;
    bit set_err;
    off = int'(reg_addr) - BASE_ADDR;
    hit = addr_dv && (off >= 0) && (off < NUM_CH);
    set_err = 1'b0;
    m_wr_en = '0;
    if (m_pend < 0 && addr_dv && rxdv && !rw_out) begin
      if (hit) begin
        m_wr_en   = NUM_CH'(1) << off;
        m_wr_data = rx_d;
      end else begin
        set_err = 1'b1;
      end
    end
    if (m_pend >= 0) begin
      if (!addr_dv) begin
        m_pend = -1; m_rd_req = '0;
      end else if (rd_ack[m_pend]) begin
        m_tx_d = rd_data[m_pend*DATA_W +: DATA_W];
        m_tx_en = 1'b1; m_rd_req = '0; m_pend = -1; m_hold = 1'b1;
      end else begin
`ifdef REG_ROUTER_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TIMEOUT) begin
          m_tx_d = '1; m_tx_en = 1'b1; m_rd_req = '0; m_pend = -1;
          m_hold = 1'b1; set_err = 1'b1;
        end
`endif
      end
    end else if (m_hold) begin
      if (!addr_dv || !rw_out) begin
        m_tx_d = '0; m_tx_en = 1'b0; m_hold = 1'b0;
      end
    end else if (addr_dv && rw_out && m_armed) begin
      m_armed = 1'b0;
      if (hit) begin
        m_pend = off; m_rd_req = NUM_CH'(1) << off; m_cnt = 0;
      end else begin
        m_tx_d = '1; m_tx_en = 1'b1; m_hold = 1'b1; set_err = 1'b1;
      end
    end
    if (!addr_dv) m_armed = 1'b1;
    if (err_clr) m_err = 1'b0;
    if (set_err) m_err = 1'b1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // compare process
  always @(negedge clk) begin
    check("cyc_tx_d", 32'(tx_d), 32'(m_tx_d));
    check("cyc_tx_en", 32'(tx_en), 32'(m_tx_en));
    check("cyc_wr_en", 32'(wr_en), 32'(m_wr_en));
    check("cyc_wr_data", 32'(wr_data), 32'(m_wr_data));
    check("cyc_rd_req", 32'(rd_req), 32'(m_rd_req));
    check("cyc_err", 32'(err), 32'(m_err));
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_d"}, 32'(tx_d), 32'h0);
    check({tag, "_tx_en"}, 32'(tx_en), 32'h0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'h0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'h0);
    check({tag, "_rd_req"}, 32'(rd_req), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // driver
  initial begin
    int rises;
    int n;
    logic prev;
    reset_n = 1'b0; reg_addr = '0; addr_dv = 1'b0; rxdv = 1'b0; rw_out = 1'b0;
    rx_d = '0; rd_ack = '0; err_clr = 1'b0;
    rd_data = 32'h96_C3_3C_5A;
    tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // write hit on channel 2
    addr_dv = 1'b1; reg_addr = 7'd6; rw_out = 1'b0; rxdv = 1'b1; rx_d = 8'h5A;
    tick();
    rxdv = 1'b0;
    check("wr_hit_en", 32'(wr_en), 32'h4);
    check("wr_hit_data", 32'(wr_data), 32'h5A);
    check("wr_hit_err", 32'(err), 32'h0);
    tick();
    check("wr_hit_pulse", 32'(wr_en), 32'h0);

    // back-to-back writes on the edge channels
    reg_addr = 7'd4; rxdv = 1'b1; rx_d = 8'hA5;
    tick();
    check("b2b_en0", 32'(wr_en), 32'h1);
    check("b2b_data0", 32'(wr_data), 32'hA5);
    reg_addr = 7'd7; rx_d = 8'hC7;
    tick();
    check("b2b_en3", 32'(wr_en), 32'h8);
    check("b2b_data3", 32'(wr_data), 32'hC7);
    rxdv = 1'b0;
    tick();
    addr_dv = 1'b0;
    tick();

    // read hit on channel 1, ack in the second request cycle
    addr_dv = 1'b1; reg_addr = 7'd5; rw_out = 1'b1;
    tick();
    check("rd_req_rise", 32'(rd_req), 32'h2);
    tick();
    check("rd_req_held", 32'(rd_req), 32'h2);
    rd_ack = 4'b0010;
    tick();
    rd_ack = '0;
    check("rd_tx_d", 32'(tx_d), 32'h3C);
    check("rd_tx_en", 32'(tx_en), 32'h1);
    check("rd_req_drop", 32'(rd_req), 32'h0);
    tick(); tick();
    check("rd_hold", 32'(tx_en), 32'h1);
    addr_dv = 1'b0;
    tick();
    check("rd_rel_tx_en", 32'(tx_en), 32'h0);
    check("rd_rel_tx_d", 32'(tx_d), 32'h0);

    // miss read, err clear, miss writes including set-wins-over-clear
    addr_dv = 1'b1; reg_addr = 7'd2; rw_out = 1'b1;
    tick();
    check("miss_rd_tx_d", 32'(tx_d), 32'hFF);
    check("miss_rd_tx_en", 32'(tx_en), 32'h1);
    check("miss_rd_err", 32'(err), 32'h1);
    addr_dv = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'h0);
    addr_dv = 1'b1; rw_out = 1'b0; reg_addr = 7'd9; rxdv = 1'b1; rx_d = 8'h11;
    tick();
    rxdv = 1'b0;
    check("miss_wr_en", 32'(wr_en), 32'h0);
    check("miss_wr_err", 32'(err), 32'h1);
    reg_addr = 7'd8; rxdv = 1'b1; err_clr = 1'b1;
    tick();
    rxdv = 1'b0; err_clr = 1'b0;
    check("set_wins", 32'(err), 32'h1);
    reg_addr = 7'd3; rxdv = 1'b1;
    tick();
    rxdv = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0; addr_dv = 1'b0;
    tick();

    // single issue per addr_dv assertion, ack held high throughout
    rd_ack = 4'b0001; addr_dv = 1'b1; reg_addr = 7'd4; rw_out = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_req[0] && !prev) rises++;
      prev = rd_req[0];
    end
    check("single_issue", 32'(rises), 32'd1);
    check("single_tx_d", 32'(tx_d), 32'h5A);
    addr_dv = 1'b0;
    tick();
    addr_dv = 1'b1;
    tick();
    check("reissue", 32'(rd_req), 32'h1);
    tick();
    check("min_latency", 32'(tx_en), 32'h1);
    addr_dv = 1'b0; rd_ack = '0;
    tick();

    // acks from other channels and writes are ignored while waiting
    addr_dv = 1'b1; reg_addr = 7'd6; rw_out = 1'b1; rd_ack = 4'b1011;
    tick(); tick(); tick(); tick();
    check("other_ack_req", 32'(rd_req), 32'h4);
    check("other_ack_tx", 32'(tx_en), 32'h0);
    rw_out = 1'b0; rxdv = 1'b1; rx_d = 8'hEE;
    tick();
    rxdv = 1'b0; rw_out = 1'b1;
    check("wait_no_wr", 32'(wr_en), 32'h0);
    rd_ack = 4'b0100;
    tick();
    rd_ack = '0;
    check("ch2_tx_d", 32'(tx_d), 32'hC3);
    addr_dv = 1'b0;
    tick();

    // unanswered read on channel 3
    addr_dv = 1'b1; reg_addr = 7'd7; rw_out = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd_req[3]) n++;
      else if (n > 0) break;
    end
`ifdef REG_ROUTER_TIMEOUT_EN
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_tx_d", 32'(tx_d), 32'hFF);
    check("timeout_tx_en", 32'(tx_en), 32'h1);
    check("timeout_err", 32'(err), 32'h1);
`else
    check("no_timeout_cycles", 32'(n), 32'd100);
    check("no_timeout_req", 32'(rd_req), 32'h8);
    check("no_timeout_err", 32'(err), 32'h0);
`endif
    addr_dv = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // abort by dropping addr_dv while waiting
    addr_dv = 1'b1; reg_addr = 7'd4; rw_out = 1'b1;
    tick();
    check("abort_req", 32'(rd_req), 32'h1);
    addr_dv = 1'b0;
    tick();
    check("abort_drop", 32'(rd_req), 32'h0);
    tick();
    check("abort_tx_en", 32'(tx_en), 32'h0);
    check("abort_err", 32'(err), 32'h0);

    // asynchronous reset while waiting
    addr_dv = 1'b1; reg_addr = 7'd6; rw_out = 1'b1;
    tick();
    check("rst_wait_req", 32'(rd_req), 32'h4);
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    addr_dv = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_wr", 32'(wr_en), 32'h0);
    check("post_rst_req", 32'(rd_req), 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_router.md
# reg_router

Parametrised register-access router between the serial-slave front end (address/data/direction strobes) and NUM_CH peripheral register channels in the audio front end. It decodes a channel from the received register address, issues single-cycle write strobes, and runs a request/acknowledge read handshake per channel. It also provides an optional timeout and a sticky error flag for unmapped or unresponsive accesses.

## Interface
- NUM_CH, 4: number of peripheral channels (1..16)
- DATA_W, 8: register data width
- ADDR_W, 7: register address width
- BASE_ADDR, 4: address of channel 0; channel k sits at BASE_ADDR+k
- TIMEOUT, 15: read-wait limit in clk cycles (used only with the macro)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- reg_addr  in  ADDR_W  register address from slave
- addr_dv  in  1  address valid, held for the whole access
- rxdv  in  1  one-cycle strobe: rx_d valid
- rw_out  in  1  1 = read (master requests data), 0 = write
- rx_d  in  DATA_W  write data from slave
- tx_d  out  DATA_W  read data to slave
- tx_en  out  1  tx_d valid
- wr_en  out  NUM_CH  one-hot write strobe
- wr_data  out  DATA_W  registered write data
- rd_req  out  NUM_CH  one-hot read request, held until ack or timeout
- rd_ack  in  NUM_CH  per-channel read acknowledge
- rd_data  in  NUM_CH*DATA_W  channel k data on bits [k*DATA_W +: DATA_W]
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation
- Decode: hit = addr_dv && (reg_addr - BASE_ADDR) < NUM_CH, with unsigned compare and reg_addr >= BASE_ADDR; ch = reg_addr - BASE_ADDR.
- FSM states: IDLE, RD_WAIT, RD_DONE.
- Write, any state except RD_WAIT:
  - Each cycle with addr_dv && rxdv && !rw_out && hit registers wr_en[ch]=1 for exactly one cycle, with wr_data=rx_d.
  - On a miss, no strobe is issued and err is set.
- Read:
  - In IDLE, addr_dv && rw_out && armed && hit → RD_WAIT, drives rd_req[ch]=1, clears armed.
  - On a miss with addr_dv && rw_out && armed → RD_DONE, tx_d = all-ones, tx_en=1, err set, armed cleared.
- RD_WAIT:
  - rd_ack[ch]=1 → capture rd_data slice ch into tx_d, tx_en=1, rd_req=0, → RD_DONE.
  - rd_ack on other channels is ignored.
- RD_DONE: holds tx_d/tx_en until addr_dv=0 or rw_out=0, then tx_d=0, tx_en=0 → IDLE.
- Abort: addr_dv falls in RD_WAIT → rd_req=0, → IDLE, tx_en stays 0, no error.
- Re-arm: armed is set whenever addr_dv=0. Only one read is issued per addr_dv assertion.
- err: set by a miss or a timeout, cleared by err_clr. Set wins when both occur in the same cycle.
- rxdv while rw_out=1 is ignored.

## Timing
- Reset values: tx_d=0, tx_en=0, wr_en=0, wr_data=0, rd_req=0, err=0, state IDLE, armed=1.
- Reset mid-access clears everything immediately; no strobe is emitted after release.
- Write latency: wr_en/wr_data appear 1 cycle after the qualifying rxdv cycle. Back-to-back rxdv cycles give back-to-back strobes.
- Read latency:
  - rd_req rises 1 cycle after the qualifying addr_dv/rw_out cycle.
  - tx_en rises 1 cycle after the cycle in which rd_ack[ch] is sampled high.
  - Minimum latency is 2 cycles, with ack in the first rd_req cycle.
- Miss read: tx_en=1 one cycle after decode.
- rd_ack is sampled only in RD_WAIT; an ack in any other state has no effect.

## Configuration
- REG_ROUTER_TIMEOUT_EN defined:
  - A counter runs in RD_WAIT.
  - After TIMEOUT cycles without ack: rd_req=0, tx_d=all-ones, tx_en=1, err set, → RD_DONE.
  - The counter clears on entry to RD_WAIT.
- REG_ROUTER_TIMEOUT_EN undefined: no counter exists, and RD_WAIT waits indefinitely, left only by ack or abort.

## Test plan
- Write hit: reset, addr_dv=1, reg_addr=6, rw_out=0, rxdv pulse with rx_d=0x5A → next cycle wr_en=4'b0100 for 1 cycle, wr_data=0x5A; err=0.
- Read hit: reg_addr=5, rw_out=1, rd_data ch1=0x3C, rd_ack[1]=1 one cycle after rd_req[1] rises → tx_d=0x3C, tx_en=1, held until addr_dv drops, then tx_d=0, tx_en=0.
- Miss: reg_addr=2 read → tx_d=0xFF, tx_en=1, err=1. Then err_clr=1 for one cycle → err=0. Then reg_addr=9 write → no wr_en, err=1.
- Single-issue: hold addr_dv=1, rw_out=1, reg_addr=4 with ack over 20 cycles → exactly one rd_req pulse train. Drop and reassert addr_dv → a second request.
- Timeout (macro on, TIMEOUT=15): read ch3 with no ack → rd_req[3] high 15 cycles, then tx_d=0xFF, tx_en=1, err=1. Macro off: rd_req stays high 100 cycles and err stays 0.
- Abort/reset: reset_n pulsed low during RD_WAIT → all outputs 0 immediately. Separately, addr_dv dropped in RD_WAIT → rd_req=0, tx_en never asserted.
